// File: rtl/io_console_uart.sv
// rtl/io_console_uart.sv - io-space console: sticky halt flag, char TX FIFO, UART transmitter, status reg.
// Optional even-parity bit per frame when IO_CONSOLE_PARITY_EN is defined.
module io_console_uart #(
   parameter int CLK_DIV = 16,
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        res,
   input  logic [31:0] db_addr,
   input  logic [31:0] db_dataOut,
   output logic [31:0] db_dataIn,
   input  logic        db_re,
   input  logic        db_we,
   input  logic        db_io,
   output logic        db_ready,
   output logic        hlt,
   output logic        uart_tx,
   output logic        tx_busy
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW    = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef IO_CONSOLE_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [7:0]       mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0] count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_rd;
   logic             push;
   logic             pop;

   logic             wr_char;
   logic             hlt_set;
   logic             rd_stb;
   logic [31:0]      status;
   logic             unused_data;

   state_t           state;
   state_t           state_nxt;
   logic [BW-1:0]    baud;
   logic [BW-1:0]    baud_nxt;
   logic [2:0]       bit_cnt;
   logic [2:0]       bit_nxt;
   logic [7:0]       shift;
   logic [7:0]       shift_nxt;
   logic             tx_nxt;
   logic             baud_end;
`ifdef IO_CONSOLE_PARITY_EN
   logic             par;
   logic             par_nxt;
`endif

   // Bus decode: only the low byte of a character write is meaningful.
   assign unused_data = ^db_dataOut[31:8];
   assign wr_char     = db_we & db_io & (db_addr == 32'd1);
   assign hlt_set     = db_we & db_io & (db_addr == 32'd0);
   assign rd_stb      = db_re & ~db_we;
   assign db_ready    = ~(wr_char & fifo_full);
   assign push        = wr_char & ~fifo_full;

   assign fifo_full   = (count == (FIFO_AW+1)'(DEPTH));
   assign fifo_empty  = (count == '0);
   assign fifo_rd     = mem[rd_ptr];
   assign status      = {20'b0, hlt, tx_busy, fifo_full, fifo_empty, 8'(count)};
   assign tx_busy     = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= db_dataOut[7:0];
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         hlt       <= 1'b0;
         db_dataIn <= '0;
      end else begin
         if (hlt_set) begin
            hlt <= 1'b1;
         end
         // Any read strobe reloads the data register; non-status reads return 0.
         if (rd_stb) begin
            db_dataIn <= (db_io && db_addr == 32'd2) ? status : 32'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state   <= S_IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         uart_tx <= 1'b1;
`ifdef IO_CONSOLE_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         baud    <= baud_nxt;
         bit_cnt <= bit_nxt;
         shift   <= shift_nxt;
         uart_tx <= tx_nxt;
`ifdef IO_CONSOLE_PARITY_EN
         par     <= par_nxt;
`endif
      end
   end

   assign baud_end = (baud == BW'(CLK_DIV - 1));

   // uart_tx is registered: tx_nxt is the line level for the state being entered.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      tx_nxt    = uart_tx;
      pop       = 1'b0;
`ifdef IO_CONSOLE_PARITY_EN
      par_nxt   = par;
`endif
      case (state)
         S_IDLE: begin
            tx_nxt = 1'b1;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_nxt = fifo_rd;
               tx_nxt    = 1'b0;
               baud_nxt  = '0;
               state_nxt = S_START;
`ifdef IO_CONSOLE_PARITY_EN
               par_nxt   = ^fifo_rd;
`endif
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_nxt  = '0;
               bit_nxt   = '0;
               tx_nxt    = shift[0];
               state_nxt = S_DATA;
            end else begin
               baud_nxt = baud + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_nxt = '0;
               if (bit_cnt == 3'd7) begin
`ifdef IO_CONSOLE_PARITY_EN
                  tx_nxt    = par;
                  state_nxt = S_PARITY;
`else
                  tx_nxt    = 1'b1;
                  state_nxt = S_STOP;
`endif
               end else begin
                  bit_nxt   = bit_cnt + 1'b1;
                  shift_nxt = shift >> 1;
                  tx_nxt    = shift[1];
               end
            end else begin
               baud_nxt = baud + 1'b1;
            end
         end
`ifdef IO_CONSOLE_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               baud_nxt  = '0;
               tx_nxt    = 1'b1;
               state_nxt = S_STOP;
            end else begin
               baud_nxt = baud + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               baud_nxt  = '0;
               state_nxt = S_IDLE;
            end else begin
               baud_nxt = baud + 1'b1;
            end
         end
         default: begin
            tx_nxt    = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_io_console_uart.sv
// tb/tb_io_console_uart.sv - directed bench for io_console_uart with frame-decoding scoreboard.
module tb_io_console_uart;

   localparam int CLK_DIV = 4;
   localparam int FIFO_AW = 2;
`ifdef IO_CONSOLE_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic [31:0] db_addr = '0;
   logic [31:0] db_dataOut = '0;
   logic [31:0] db_dataIn;
   logic        db_re = 1'b0;
   logic        db_we = 1'b0;
   logic        db_io = 1'b0;
   logic        db_ready;
   logic        hlt;
   logic        uart_tx;
   logic        tx_busy;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   bit          mon_en = 1'b0;

   io_console_uart #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk), .res(res), .db_addr(db_addr), .db_dataOut(db_dataOut),
      .db_dataIn(db_dataIn), .db_re(db_re), .db_we(db_we), .db_io(db_io),
      .db_ready(db_ready), .hlt(hlt), .uart_tx(uart_tx), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] stat(bit h, bit busy, bit full, bit empty, int cnt);
      return {20'b0, h, busy, full, empty, 8'(cnt)};
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] d, output int stalls);
      db_addr = a; db_dataOut = d; db_we = 1'b1; db_re = 1'b0; db_io = 1'b1;
      stalls = 0;
      while (db_ready !== 1'b1 && stalls < 2000) begin
         @(negedge clk);
         stalls++;
      end
      if (a == 32'd1 && db_ready === 1'b1) exp_q.push_back(d[7:0]);
      @(posedge clk);
      @(negedge clk);
      db_we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input bit io, output logic [31:0] v);
      db_addr = a; db_io = io; db_re = 1'b1; db_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      db_re = 1'b0;
      v = db_dataIn;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((tx_busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 3000), 32'd1);
   endtask

   // Frame receiver: one sample per clock on the falling edge, decoded when a full frame is in.
   logic       rxs [FRAME_CYC];
   int         rx_cyc = 0;
   bit         rx_active = 1'b0;
   bit         busy_ok;
   bit         fmt_ok;
   logic [7:0] rx_data;
   logic [8:0] exp9;

   always @(negedge clk) begin
      if (!res || !mon_en) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (uart_tx === 1'b0) begin
            rx_active = 1'b1;
            rxs[0]    = 1'b0;
            busy_ok   = (tx_busy === 1'b1);
            rx_cyc    = 1;
         end
      end else begin
         rxs[rx_cyc] = uart_tx;
         if (tx_busy !== 1'b1) busy_ok = 1'b0;
         rx_cyc++;
         if (rx_cyc == FRAME_CYC) begin
            rx_active = 1'b0;
            fmt_ok    = busy_ok;
            for (int b = 0; b < FRAME_BITS; b++)
               for (int k = 1; k < CLK_DIV; k++)
                  if (rxs[b*CLK_DIV+k] !== rxs[b*CLK_DIV]) fmt_ok = 1'b0;
            for (int i = 0; i < 8; i++) rx_data[i] = rxs[(i+1)*CLK_DIV];
            if (rxs[0] !== 1'b0 || rxs[(FRAME_BITS-1)*CLK_DIV] !== 1'b1) fmt_ok = 1'b0;
`ifdef IO_CONSOLE_PARITY_EN
            if (rxs[9*CLK_DIV] !== ^rx_data) fmt_ok = 1'b0;
`endif
            if (exp_q.size() > 0) exp9 = {1'b0, exp_q.pop_front()};
            else exp9 = 9'h1ff;
            chk("rx_frame_format", 32'(fmt_ok), 32'd1);
            chk("rx_frame_data", {24'b0, rx_data}, {23'b0, exp9});
         end
      end
   end

   initial begin
      int          st;
      logic [31:0] v;
      bit          low_seen;

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(db_ready), 32'd1);
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_hlt", 32'(hlt), 32'd0);
      chk("rst_datain", db_dataIn, 32'd0);
      res = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Single character: exact start latency and frame length.
      wr(32'd1, 32'h0000_0041, st);
      chk("t1_stall", 32'(st), 32'd0);
      chk("t1_idle_after_accept", 32'(uart_tx), 32'd1);
      @(negedge clk);
      chk("t1_start_bit", 32'(uart_tx), 32'd0);
      chk("t1_busy_start", 32'(tx_busy), 32'd1);
      repeat (FRAME_CYC) @(negedge clk);
      chk("t1_busy_after_stop", 32'(tx_busy), 32'd0);
      chk("t1_line_idle", 32'(uart_tx), 32'd1);
      chk("t1_frame_seen", 32'(exp_q.size()), 32'd0);
      wr(32'd1, 32'hFFFF_FF43, st);
      wait_drain("t1_drain");

      // Status with one frame in flight and two queued, then after drain.
      wr(32'd1, 32'h41, st);
      wr(32'd1, 32'h42, st);
      wr(32'd1, 32'h43, st);
      rd(32'd2, 1'b1, v);
      chk("t4_status_busy", v, stat(0, 1, 0, 0, 2));
      wait_drain("t4_drain");
      rd(32'd2, 1'b1, v);
      chk("t4_status_idle", v, stat(0, 0, 0, 1, 0));
      repeat (5) @(negedge clk);
      chk("t4_datain_held", db_dataIn, stat(0, 0, 0, 1, 0));
      rd(32'd7, 1'b1, v);
      chk("t4_other_addr_read", v, 32'd0);
      rd(32'd2, 1'b0, v);
      chk("t4_non_io_read", v, 32'd0);

      // Six back-to-back chars: the sixth stalls until the second pop.
      for (int i = 0; i < 6; i++) begin
         wr(32'd1, 32'h41 + 32'(i), st);
         chk($sformatf("t2_stall_%0d", i), 32'(st), (i < 5) ? 32'd0 : 32'(FRAME_CYC - 2));
      end
      wait_drain("t2_drain");
      rd(32'd2, 1'b1, v);
      chk("t2_status_after", v, stat(0, 0, 0, 1, 0));

      // Sticky halt.
      chk("t3_hlt_before", 32'(hlt), 32'd0);
      wr(32'd0, 32'hDEAD_BEEF, st);
      chk("t3_hlt_set", 32'(hlt), 32'd1);
      wr(32'd0, 32'h0, st);
      chk("t3_second_hlt_stall", 32'(st), 32'd0);
      wr(32'd5, 32'h33, st);
      chk("t3_hlt_sticky", 32'(hlt), 32'd1);
      rd(32'd2, 1'b1, v);
      chk("t3_status_hlt", v, stat(1, 0, 0, 1, 0));
      #2 res = 1'b0;
      #1 chk("t3_hlt_cleared", 32'(hlt), 32'd0);
      repeat (2) @(negedge clk);
      res = 1'b1;
      @(negedge clk);

      // Reset in the middle of data bit 0 of a frame with one char still queued.
      wr(32'd1, 32'h54, st);
      wr(32'd1, 32'h66, st);
      repeat (6) @(negedge clk);
      chk("t5_pre_data_bit", 32'(uart_tx), 32'd0);
      #2 res = 1'b0;
      exp_q.delete();
      #1;
      chk("t5_rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("t5_rst_busy", 32'(tx_busy), 32'd0);
      chk("t5_rst_datain", db_dataIn, 32'd0);
      repeat (2) @(negedge clk);
      res = 1'b1;
      low_seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || tx_busy !== 1'b0) low_seen = 1'b1;
      end
      chk("t5_line_quiet", 32'(low_seen), 32'd0);
      rd(32'd2, 1'b1, v);
      chk("t5_status_empty", v, stat(0, 0, 0, 1, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
